key_debounce_multi: RTL and testbench

// - Parametrised N-channel successor to the single-key start_pg de-twitter in front of the UART programmer.
// - Debounces CH raw switch/button inputs from FPGA pins in the fpga_clk domain.
// - Per channel it provides a clean level, one-cycle press/release pulses, a long-press pulse and an optional toggle latch.
// - Feeds upg_rst generation, CPU mode keys and any button-driven control in CPU_TOP.

---
 rtl/key_debounce_multi_pkg.sv | 29 ++
 rtl/key_debounce_multi_if.sv | 32 +++
 rtl/key_debounce_multi_ch.sv | 96 +++++++++
 rtl/key_debounce_multi.sv | 65 ++++++
 tb/tb_key_debounce_multi.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_multi_pkg.sv
// Shared constants and types for the multi-channel key debouncer.
// Tick counts derive from the fpga_clk frequency.
package key_debounce_multi_pkg;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 2;
  localparam int unsigned LONG_MS     = 20;

  function automatic int unsigned ms_to_cyc(
    input int unsigned hz,
    input int unsigned ms
  );
    return (hz / 1000) * ms;
  endfunction

  localparam int unsigned DEF_STABLE_CYC =
    ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned DEF_LONG_CYC =
    ms_to_cyc(CLK_HZ, LONG_MS);

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
    logic mode;
  } key_evt_t;

endpackage

// File: rtl/key_debounce_multi_if.sv
// Pin-side inputs and per-channel debounced outputs.
// master drives the pins, slave is the debouncer.
interface key_debounce_multi_if #(
  parameter int CH = 4
);

  logic [CH-1:0] key_in;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_release;
  logic [CH-1:0] key_long;
  logic [CH-1:0] key_mode;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_mode
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_long,
    output key_mode
  );

endinterface

// File: rtl/key_debounce_multi_ch.sv
// One debounce channel: sync, stability count, edge pulses,
// long-press timer and optional toggle latch.
module key_debounce_ch
  import key_debounce_multi_pkg::*;
#(
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter bit          INV        = 1'b0,
  parameter bit          TOGGLE     = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key_in,
  output key_evt_t evt
);

  localparam int DW = $clog2(STABLE_CYC);
  localparam int HW = $clog2(LONG_CYC + 1);

  localparam logic [DW-1:0] DMAX = DW'(STABLE_CYC - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HPRE = HW'(LONG_CYC - 2);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          mode_q, mode_d;
  logic          s;
  logic          rise;

  always_comb begin
    sync_d   = {sync_q[0], key_in};
    s        = sync_q[1] ^ INV;
    stable_d = stable_q;
    dcnt_d   = '0;
    if (s != stable_q) begin
      if (dcnt_q == DMAX) begin
        stable_d = s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    rise    = stable_d & ~stable_q;
    press_d = rise;
    rel_d   = ~stable_d & stable_q;

    // hcnt saturates one past the fire point, so no repeat
    hcnt_d = hcnt_q;
    if (!stable_d || rise) begin
      hcnt_d = '0;
    end else if (hcnt_q != HMAX) begin
      hcnt_d = hcnt_q + HW'(1);
    end
    long_d = stable_q & stable_d & (hcnt_q == HPRE);

    if (TOGGLE) begin
      mode_d = mode_q ^ press_q;
    end else begin
      mode_d = stable_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      hcnt_q   <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      hcnt_q   <= hcnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      mode_q   <= mode_d;
    end
  end

  assign evt.level = stable_q;
  assign evt.press = press_q;
  assign evt.rel   = rel_q;
  assign evt.lng   = long_q;
  assign evt.mode  = mode_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: parameter checks plus one
// independent key_debounce_ch per channel.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned STABLE_CYC  = DEF_STABLE_CYC,
  parameter int unsigned LONG_CYC    = DEF_LONG_CYC,
  parameter logic [31:0] INV_MASK    = '0,
  parameter logic [31:0] TOGGLE_MASK = '0
) (
  input logic fpga_clk,
  input logic fpga_rst,
  key_debounce_multi_if.slave kif
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("CH must be 1..32");
  end
  if (STABLE_CYC < 2) begin : g_bad_stable
    $error("STABLE_CYC must be >= 2");
  end
  if (LONG_CYC <= STABLE_CYC) begin : g_bad_long
    $error("LONG_CYC must exceed STABLE_CYC");
  end

  key_evt_t      evt [CH];
  logic [CH-1:0] lvl, prs, rel, lng, mde;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CYC (STABLE_CYC),
      .LONG_CYC   (LONG_CYC),
      .INV        (INV_MASK[i]),
      .TOGGLE     (TOGGLE_MASK[i])
    ) u_ch (
      .clk    (fpga_clk),
      .rst_n  (fpga_rst),
      .key_in (kif.key_in[i]),
      .evt    (evt[i])
    );
  end

  always_comb begin
    lvl = '0;
    prs = '0;
    rel = '0;
    lng = '0;
    mde = '0;
    for (int i = 0; i < int'(CH); i++) begin
      lvl[i] = evt[i].level;
      prs[i] = evt[i].press;
      rel[i] = evt[i].rel;
      lng[i] = evt[i].lng;
      mde[i] = evt[i].mode;
    end
  end

  assign kif.key_level   = lvl;
  assign kif.key_press   = prs;
  assign kif.key_release = rel;
  assign kif.key_long    = lng;
  assign kif.key_mode    = mde;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: expected pulses
// are queued at stimulus time and matched cycle by cycle.
module tb_key_debounce_multi;

  localparam int         CH  = 4;
  localparam int         SC  = 4;
  localparam int         LC  = 16;
  localparam logic [3:0] INV = 4'b1000;
  localparam logic [3:0] TGL = 4'b0100;
  localparam int         LAT = 2 + SC;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  sbq[$];
  logic [CH-1:0] mode_prev = '0;
  string knm [4] = '{"press", "release", "long", "mode"};

  key_debounce_multi_if #(.CH(CH)) kif ();

  key_debounce_multi #(
    .CH          (CH),
    .STABLE_CYC  (SC),
    .LONG_CYC    (LC),
    .INV_MASK    (32'(INV)),
    .TOGGLE_MASK (32'(TGL))
  ) dut (
    .fpga_clk (clk),
    .fpga_rst (rst_n),
    .kif      (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_ev(input int c, input int ch, input int k);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    sbq.push_back(e);
  endtask

  task automatic exp_press(input int c, input int ch);
    exp_ev(c + LAT, ch, 0);
    exp_ev(TGL[ch] ? c + LAT + 1 : c + LAT, ch, 3);
  endtask

  task automatic exp_rel(input int c, input int ch);
    exp_ev(c + LAT, ch, 1);
    if (!TGL[ch]) exp_ev(c + LAT, ch, 3);
  endtask

  task automatic exp_long(input int c, input int ch);
    exp_ev(c + LAT + LC - 1, ch, 2);
  endtask

  function automatic logic obs_bit(input int ch, input int k);
    case (k)
      0:       return kif.key_press[ch];
      1:       return kif.key_release[ch];
      2:       return kif.key_long[ch];
      default: return kif.key_mode[ch] != mode_prev[ch];
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < CH; ch++) begin
        for (int k = 0; k < 4; k++) begin
          logic o;
          logic e;
          o = obs_bit(ch, k);
          e = 1'b0;
          for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].cyc == cyc && sbq[j].ch == ch &&
                sbq[j].kind == k) begin
              sbq.delete(j);
              e = 1'b1;
              break;
            end
          end
          if (o || e)
            chk($sformatf("%s ch%0d @%0d", knm[k], ch, cyc),
                32'(o), 32'(e));
        end
      end
    end
    mode_prev <= kif.key_mode;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    int r;
    kif.key_in = 4'b1000;
    rst_n = 1'b0;
    tick(3);
    chk("rst_level",   32'(kif.key_level),   0);
    chk("rst_press",   32'(kif.key_press),   0);
    chk("rst_release", 32'(kif.key_release), 0);
    chk("rst_long",    32'(kif.key_long),    0);
    chk("rst_mode",    32'(kif.key_mode),    0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_level", 32'(kif.key_level), 0);

    // clean press with long hold on ch0
    c = cyc;
    kif.key_in[0] = 1'b1;
    exp_press(c, 0);
    exp_long(c, 0);
    tick(10);
    chk("held_level0", 32'(kif.key_level), 32'h1);
    tick(20);
    kif.key_in[0] = 1'b0;
    exp_rel(cyc, 0);
    tick(12);

    // bouncing edge on ch1
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      kif.key_in[1] = (i % 2 == 0);
      if (i < 4) tick(2);
    end
    exp_press(c + 8, 1);
    tick(12);
    kif.key_in[1] = 1'b0;
    exp_rel(cyc, 1);
    tick(12);

    // short press on ch0, no long
    c = cyc;
    kif.key_in[0] = 1'b1;
    exp_press(c, 0);
    tick(10);
    kif.key_in[0] = 1'b0;
    exp_rel(cyc, 0);
    tick(20);

    // toggle channel pressed twice
    for (int k = 0; k < 2; k++) begin
      c = cyc;
      kif.key_in[2] = 1'b1;
      exp_press(c, 2);
      tick(8);
      kif.key_in[2] = 1'b0;
      exp_rel(cyc, 2);
      tick(12);
      chk($sformatf("mode2_after_%0d", k),
          32'(kif.key_mode[2]), (k == 0) ? 1 : 0);
    end

    // inverted channel
    chk("lvl3_idle", 32'(kif.key_level[3]), 0);
    c = cyc;
    kif.key_in[3] = 1'b0;
    exp_press(c, 3);
    tick(10);
    chk("lvl3_held", 32'(kif.key_level[3]), 1);
    kif.key_in[3] = 1'b1;
    exp_rel(cyc, 3);
    tick(12);

    // all channels at once
    c = cyc;
    kif.key_in = 4'b0111;
    for (int ch = 0; ch < CH; ch++) begin
      exp_press(c, ch);
      exp_long(c, ch);
    end
    tick(10);
    chk("all_level", 32'(kif.key_level), 32'hf);
    tick(15);
    kif.key_in = 4'b1000;
    for (int ch = 0; ch < CH; ch++) exp_rel(cyc, ch);
    tick(12);

    // reset mid-debounce on ch0 with ch1 held
    c = cyc;
    kif.key_in[1] = 1'b1;
    exp_press(c, 1);
    tick(8);
    kif.key_in[0] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(kif.key_level), 0);
    chk("mid_rst_mode",  32'(kif.key_mode),  0);
    chk("mid_rst_press", 32'(kif.key_press), 0);
    tick(3);
    rst_n = 1'b1;
    r = cyc;
    exp_press(r, 0);
    exp_press(r, 1);
    tick(10);
    kif.key_in = 4'b1000;
    exp_rel(cyc, 0);
    exp_rel(cyc, 1);
    tick(12);

    foreach (sbq[j])
      chk($sformatf("missed %s ch%0d @%0d", knm[sbq[j].kind],
          sbq[j].ch, sbq[j].cyc), 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
